// File: rtl/irq_nios2_qsys_oci_ram_arbiter.sv
// irq_nios2_qsys_oci_ram_arbiter: shares the OCI debug RAM between the Avalon debug slave and JTAG commands
module irq_nios2_qsys_oci_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              debugaccess,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, J_WAIT, C_WAIT} state_t;
  state_t state, state_nx;
  logic jpend, jwr, ld_pend, last_j;
  logic sel_a, sel_n, q, idle, creq, gnt_j, gnt_c, cwr, done, busy;
  logic [ADDR_W-1:0] jtag_addr, ld_addr;
  logic [31:0] jwdata;
  logic unused;
  assign unused = ^{jdo[37:35], jdo[2:0]};
  assign sel_a = take_action_ocimem_a & ~take_action_ocimem_b;
  assign sel_n = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign q = take_action_ocimem_b | (sel_a & jdo[17]) | sel_n;
  assign idle = state == IDLE;
  assign creq = avs_read | avs_write;
  assign gnt_j = idle & jpend & (~creq | ~last_j);
  assign gnt_c = idle & creq & ~gnt_j;
  assign cwr = gnt_c & ~avs_read;
  assign done = (gnt_j & jwr) | (state == J_WAIT);
  assign busy = jpend & ~done;
  assign monitor_ready = ~jpend;
  always_comb begin
    state_nx = (gnt_j & ~jwr) ? J_WAIT : (gnt_c & avs_read) ? C_WAIT : IDLE;
    ram_addr = gnt_c ? avs_address : jtag_addr;
    ram_wdata = gnt_c ? avs_writedata : jwdata;
    ram_be = gnt_c ? avs_byteenable : 4'hF;
    ram_we = reset_n & ((gnt_j & jwr) | (cwr & debugaccess));
    avs_waitrequest = ~(reset_n & (cwr | state == C_WAIT));
    avs_readdata = (reset_n && state == C_WAIT) ? ram_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      jpend <= 1'b0;
      jwr <= 1'b0;
      jwdata <= '0;
      jtag_addr <= '0;
      ld_pend <= 1'b0;
      ld_addr <= '0;
      last_j <= 1'b0;
      MonDReg <= '0;
      monitor_error <= 1'b0;
    end else begin
      state <= state_nx;
      if (gnt_j) last_j <= 1'b1;
      else if (gnt_c) last_j <= 1'b0;
      if (state == J_WAIT) MonDReg <= ram_rdata;
      if (q && !busy) begin
        jpend <= 1'b1;
        jwr <= take_action_ocimem_b;
      end else if (done) jpend <= 1'b0;
      if (take_action_ocimem_b && !busy) jwdata <= jdo[34:3];
      if (q && busy) monitor_error <= 1'b1;
      else if (sel_a) monitor_error <= 1'b0;
      // a bare address load during a pending op is held until that op has incremented
      if (sel_a && !busy) jtag_addr <= jdo[18 +: ADDR_W];
      else if (done) jtag_addr <= ld_pend ? ld_addr : jtag_addr + ADDR_W'(1);
      if (sel_a && busy && !jdo[17]) begin
        ld_pend <= 1'b1;
        ld_addr <= jdo[18 +: ADDR_W];
      end else if (done) ld_pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_irq_nios2_qsys_oci_ram_arbiter.sv
// tb_irq_nios2_qsys_oci_ram_arbiter: random transactions checked against a transaction-level memory/arbitration model
module tb_irq_nios2_qsys_oci_ram_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic take_action_ocimem_a = 1'b0, take_action_ocimem_b = 1'b0, take_no_action_ocimem_a = 1'b0;
  logic [31:0] MonDReg;
  logic monitor_ready, monitor_error;
  logic [7:0] avs_address = '0;
  logic avs_read = 1'b0, avs_write = 1'b0, debugaccess = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0] avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic avs_waitrequest;
  logic [7:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0] ram_be;
  logic ram_we;
  irq_nios2_qsys_oci_ram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable), .debugaccess(debugaccess),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [256];
  logic [31:0] mem_ref [256];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) for (int b = 0; b < 4; b++) if (ram_be[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
  end
  int we_cnt = 0;
  logic [7:0] we_addr;
  logic [31:0] we_data;
  logic [3:0] we_be;
  always @(negedge clk) begin
    #1;
    if (ram_we) begin
      we_cnt++;
      we_addr = ram_addr;
      we_data = ram_wdata;
      we_be = ram_be;
    end
  end
  int total = 0, bad = 0;
  logic [7:0] jaddr_ref = '0;
  bit last_j = 1'b0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [37:0] jd_w(input logic [31:0] d);
    logic [37:0] j = '0;
    j[34:3] = d;
    return j;
  endfunction
  function automatic logic [37:0] jd_a(input logic [7:0] a, input bit rd);
    logic [37:0] j = '0;
    j[25:18] = a;
    j[17] = rd;
    return j;
  endfunction
  task automatic pulse(input int kind, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a = kind == 0;
    take_action_ocimem_b = kind == 1;
    take_no_action_ocimem_a = kind == 2;
    @(posedge clk);
    #1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask
  task automatic jwait(output int lat);
    @(negedge clk);
    #1;
    lat = 0;
    while (!monitor_ready && lat < 50) begin
      lat++;
      @(negedge clk);
      #1;
    end
  endtask
  task automatic jtag_op(input int kind, input logic [37:0] j, output int lat);
    pulse(kind, j);
    jwait(lat);
  endtask
  task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                        input bit dbg, output int lat, output logic [31:0] rd, output bit we);
    @(negedge clk);
    avs_address = a;
    avs_read = !wr;
    avs_write = wr;
    avs_writedata = d;
    avs_byteenable = be;
    debugaccess = dbg;
    #1;
    lat = 1;
    while (avs_waitrequest && lat < 50) begin
      @(negedge clk);
      #1;
      lat++;
    end
    rd = avs_readdata;
    we = ram_we;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask
  task automatic cpu_apply(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) mem_ref[a][8*b +: 8] = d[8*b +: 8];
  endtask
  task automatic do_jwrite(input logic [31:0] d);
    int lat;
    int w0 = we_cnt;
    jtag_op(1, jd_w(d), lat);
    chk("jw_lat", lat, 1);
    chk("jw_cnt", we_cnt - w0, 1);
    chk("jw_addr", we_addr, jaddr_ref);
    chk("jw_data", we_data, d);
    chk("jw_be", we_be, 4'hF);
    mem_ref[jaddr_ref] = d;
    jaddr_ref++;
    last_j = 1'b1;
  endtask
  task automatic do_jread();
    int lat;
    jtag_op(2, '0, lat);
    chk("jr_lat", lat, 2);
    chk("jr_data", MonDReg, mem_ref[jaddr_ref]);
    jaddr_ref++;
    last_j = 1'b1;
  endtask
  task automatic do_jload(input logic [7:0] a, input bit rd);
    int lat;
    jtag_op(0, jd_a(a, rd), lat);
    jaddr_ref = a;
    chk("jl_err", monitor_error, 0);
    chk("jl_lat", lat, rd ? 2 : 0);
    if (rd) begin
      chk("jl_data", MonDReg, mem_ref[a]);
      jaddr_ref++;
      last_j = 1'b1;
    end
  endtask
  task automatic do_cwrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input bit dbg);
    int lat;
    logic [31:0] rd;
    bit we;
    int w0 = we_cnt;
    cpu_op(1'b1, a, d, be, dbg, lat, rd, we);
    chk("cw_lat", lat, 1);
    chk("cw_we", we, dbg);
    chk("cw_cnt", we_cnt - w0, dbg);
    if (dbg) cpu_apply(a, d, be);
    last_j = 1'b0;
  endtask
  task automatic do_cread(input logic [7:0] a);
    int lat;
    logic [31:0] rd;
    bit we;
    cpu_op(1'b0, a, '0, 4'hF, 1'b0, lat, rd, we);
    chk("cr_lat", lat, 2);
    chk("cr_data", rd, mem_ref[a]);
    last_j = 1'b0;
  endtask
  task automatic do_conflict(input bit jw, input logic [31:0] jd, input bit cw, input logic [7:0] a,
                             input logic [31:0] cd, input logic [3:0] be, input bit dbg);
    bit jwin = !last_j;
    int jl, cl;
    logic [31:0] rd, exp_mon, exp_rd;
    bit we;
    logic [7:0] ja = jaddr_ref;
    fork
      jtag_op(jw ? 1 : 2, jw ? jd_w(jd) : '0, jl);
      begin
        @(negedge clk);
        cpu_op(cw, a, cd, be, dbg, cl, rd, we);
      end
    join
    // winner's access is applied to the model first
    if (jwin) begin
      exp_mon = mem_ref[ja];
      if (jw) mem_ref[ja] = jd;
      exp_rd = mem_ref[a];
      if (cw && dbg) cpu_apply(a, cd, be);
    end else begin
      exp_rd = mem_ref[a];
      if (cw && dbg) cpu_apply(a, cd, be);
      exp_mon = mem_ref[ja];
      if (jw) mem_ref[ja] = jd;
    end
    chk("cf_jlat", jl, (jw ? 1 : 2) + (jwin ? 0 : (cw ? 1 : 2)));
    chk("cf_clat", cl, (cw ? 1 : 2) + (jwin ? (jw ? 1 : 2) : 0));
    if (!jw) chk("cf_mon", MonDReg, exp_mon);
    if (cw) chk("cf_we", we, dbg);
    else chk("cf_rd", rd, exp_rd);
    jaddr_ref = ja + 8'd1;
    last_j = !jwin;
  endtask
  initial begin
    int lat;
    logic [7:0] x;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      mem_ref[i] = mem[i];
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      jdo = {$urandom, $urandom};
      {take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a} = 3'($urandom);
      {avs_read, avs_write, debugaccess} = 3'($urandom);
      avs_address = 8'($urandom);
      avs_writedata = $urandom;
      avs_byteenable = 4'($urandom);
      #1;
      chk("rst_mon", MonDReg, 0);
      chk("rst_rdy", monitor_ready, 1);
      chk("rst_err", monitor_error, 0);
      chk("rst_rd", avs_readdata, 0);
      chk("rst_wait", avs_waitrequest, 1);
      chk("rst_we", ram_we, 0);
    end
    @(negedge clk);
    {take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a} = 3'b0;
    {avs_read, avs_write, debugaccess} = 3'b0;
    reset_n = 1'b1;
    #1;
    chk("rel_rdy", monitor_ready, 1);
    do_jload(8'h10, 1'b0);
    do_jwrite(32'hDEADBEEF);
    do_cread(8'h10);
    do_conflict(1'b0, '0, 1'b0, 8'($urandom), '0, 4'hF, 1'b0);
    do_jread();
    do_conflict(1'b0, '0, 1'b0, 8'($urandom), '0, 4'hF, 1'b0);
    do_cwrite(8'h20, 32'h12345678, 4'hF, 1'b0);
    do_cread(8'h20);
    do_cwrite(8'h20, 32'h12345678, 4'hF, 1'b1);
    do_cread(8'h20);
    pulse(0, jd_a(8'hFF, 1'b1));
    pulse(2, '0);
    jwait(lat);
    chk("ov_lat", lat, 1);
    chk("ov_err", monitor_error, 1);
    chk("ov_data", MonDReg, mem_ref[8'hFF]);
    jaddr_ref = 8'h00;
    last_j = 1'b1;
    do_jwrite($urandom);
    do_jload(8'($urandom), 1'b0);
    x = 8'($urandom);
    pulse(2, '0);
    pulse(0, jd_a(x, 1'b0));
    jwait(lat);
    chk("dl_lat", lat, 1);
    chk("dl_data", MonDReg, mem_ref[jaddr_ref]);
    chk("dl_err", monitor_error, 0);
    jaddr_ref = x;
    do_jwrite($urandom);
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: do_jwrite($urandom);
        1: do_jload(8'($urandom), 1'($urandom));
        2: do_jread();
        3: do_cwrite(8'($urandom), $urandom, 4'($urandom), 1'($urandom));
        4: do_cread(8'($urandom));
        default: do_conflict(1'($urandom), $urandom, 1'($urandom), 8'($urandom), $urandom, 4'($urandom), 1'($urandom));
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_nios2_qsys_oci_ram_arbiter.md
# irq_nios2_qsys_oci_ram_arbiter

Arbiter and command sequencer for the Nios II on-chip debug (OCI) RAM. It shares one single-port debug RAM between the CPU's Avalon debug slave and the JTAG debug path, which delivers clk-domain `take_*_ocimem_*` pulses and the `jdo` shift word. It turns JTAG commands into RAM reads and writes, returns read data in `MonDReg` with `monitor_ready`/`monitor_error` status, and arbitrates conflicts so that neither side starves.

## Interface
- ADDR_W, 8, RAM word-address width
- DATA_W, 32, RAM/Avalon data width (fixed at 32 by `jdo` layout)

Ports (clk and reset_n first):
- clk  in  1  single system clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- jdo  in  38  JTAG data word
- take_action_ocimem_a  in  1  address-load pulse
- take_action_ocimem_b  in  1  write-data pulse
- take_no_action_ocimem_a  in  1  read-next pulse
- MonDReg  out  32  JTAG read-data register
- monitor_ready  out  1  1 = no JTAG op pending
- monitor_error  out  1  sticky command-overrun flag
- avs_address  in  ADDR_W  CPU word address
- avs_read  in  1  CPU read request
- avs_write  in  1  CPU write request
- avs_writedata  in  32  CPU write data
- avs_byteenable  in  4  CPU byte enables
- debugaccess  in  1  CPU write permitted when 1
- avs_readdata  out  32  CPU read data
- avs_waitrequest  out  1  Avalon wait
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM write data
- ram_be  out  4  RAM byte enables
- ram_we  out  1  RAM write strobe
- ram_rdata  in  32  RAM read data, valid 1 cycle after address

## Operation
- JTAG decode:
  - ocimem_a loads jtag_addr ← jdo[25:18] and clears monitor_error. If jdo[17]=1, it also queues a read at the new address.
  - ocimem_b queues a write of jdo[34:3] with all bytes enabled.
  - no_action_ocimem_a queues a read.
  - If several pulses arrive in one cycle, priority is b > a > no_action; the losers are ignored without error.
- One JTAG op can be pending at a time (jpend).
  - A queuing pulse while jpend=1 is dropped and sets monitor_error=1.
  - An address load alone is always accepted, even while an op is pending. It takes effect after the pending op's increment.
- After each JTAG read or write completes, jtag_addr increments by 1 and wraps from 2^ADDR_W−1 to 0.
- FSM states and transitions:
  - IDLE: arbitrate.
    - JTAG write: goes to IDLE.
    - JTAG read: goes to J_WAIT.
    - CPU read: goes to C_WAIT.
    - CPU write: goes to IDLE.
  - J_WAIT: MonDReg ← ram_rdata; go to IDLE.
  - C_WAIT: avs_readdata = ram_rdata, avs_waitrequest=0; go to IDLE.
- Arbitration happens only in IDLE, between jpend and CPU (avs_read|avs_write).
  - If only one side requests, it wins.
  - If both request, the side not granted last wins.
  - last_grant updates on every grant and resets to CPU, so JTAG wins the first conflict.
- CPU write with debugaccess=0: completes normally (waitrequest low), but ram_we stays 0.
- avs_read and avs_write both high: treated as a read.
- RAM outputs are combinational from the grant in IDLE. When no access is granted, ram_we=0 and ram_addr=jtag_addr.

## Timing
- Reset values:
  - Outputs: MonDReg=0, monitor_ready=1, monitor_error=0, avs_readdata=0, avs_waitrequest=1, ram_we=0.
  - Internal: state=IDLE, jpend=0, jtag_addr=0, last_grant=CPU.
- Reset asserted mid-operation: the pending op is dropped, no RAM write occurs in that cycle, and the next cycle starts from the reset values.
- avs_waitrequest is 0 only in two cases: a granted CPU write cycle in IDLE, or the C_WAIT cycle. It is 1 otherwise, including while the CPU is not requesting.
- CPU write latency: 1 cycle. CPU read latency: 2 cycles. Minimum back-to-back reads: one every 2 cycles.
- JTAG pulse at cycle T: jpend=1 and monitor_ready=0 from T+1.
  - Write granted at T+1: RAM written at T+1; monitor_ready=1 and jtag_addr+1 from T+2.
  - Read granted at T+1: MonDReg valid and monitor_ready=1 from T+3.
  - Each lost arbitration adds 1 cycle for a CPU write or 2 cycles for a CPU read.
- Pulses in the same cycle as completion: jpend clears and then re-sets; this is not an error.

## Test plan
- Reset held 3 cycles with random inputs -> all outputs at reset values, ram_we=0 throughout.
- JTAG address load jdo[25:18]=0x10, then write jdo[34:3]=0xDEADBEEF -> ram_we=1, ram_addr=0x10, ram_be=0xF for one cycle; monitor_ready low exactly 1 cycle; jtag_addr=0x11.
- CPU read at 0x10 after that write -> avs_waitrequest low in the 2nd cycle with avs_readdata=0xDEADBEEF.
- CPU read and JTAG read pending in the same IDLE cycle -> JTAG granted first and CPU read completes 2 cycles later. A repeat conflict -> CPU granted first.
- CPU write 0x12345678 to 0x20 with debugaccess=0 -> waitrequest low, no ram_we, and a later read of 0x20 returns the old data. Same write with debugaccess=1 -> RAM written.
- Address load 0xFF with jdo[17]=1, then a second read pulse while the first is pending -> monitor_error=1 and only one read performed; jtag_addr wraps to 0x00. A following address load -> monitor_error=0.
